// File: rtl/wed_capture_if.sv
// PSL buffer-write and response signals seen by the WED capture stage.
// The PSL side drives everything (master); the capture block only listens (slave).
interface wed_capture_if;
    logic         ha_bwvalid;
    logic [0:7]   ha_bwtag;
    logic         ha_bwtagpar;
    logic [0:5]   ha_bwad;
    logic [0:511] ha_bwdata;
    logic [0:7]   ha_bwpar;
    logic         ha_rvalid;
    logic [0:7]   ha_rtag;
    logic         ha_rtagpar;
    logic [0:7]   ha_response;

    // Valid/ready note: these streams carry no back-pressure; a beat or a
    // response exists exactly in the cycles where its valid is high.
    modport master (
        output ha_bwvalid, ha_bwtag, ha_bwtagpar, ha_bwad, ha_bwdata, ha_bwpar,
        output ha_rvalid, ha_rtag, ha_rtagpar, ha_response
    );
    modport slave (
        input ha_bwvalid, ha_bwtag, ha_bwtagpar, ha_bwad, ha_bwdata, ha_bwpar,
        input ha_rvalid, ha_rtag, ha_rtagpar, ha_response
    );
endinterface

// File: rtl/wed_capture.sv
// Captures the two 512-bit WED beats for one armed tag, checks parity and
// qualifies completion against the PSL response code.
module wed_capture #(
    parameter bit         PARITY_EN = 1'b1,
    parameter logic [7:0] RESP_DONE = 8'h00
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic [0:7]    arm_tag,
    wed_capture_if.slave  psl,
    output logic          busy,
    output logic          wed_valid,
    output logic [0:1023] wed_data,
    output logic          wed_error,
    output logic [0:7]    wed_status,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [0:7]    tag_q, tag_n;
    logic [1:0]    mask_q, mask_n;
    logic          pend_q, pend_n;
    logic [0:7]    pcode_q, pcode_n;
    logic          busy_n, valid_n, error_n;
    logic [0:7]    status_n;
    logic [0:1023] data_n;

    logic       bw_hit, r_hit;
    logic       bw_tagpar_bad, r_tagpar_bad, data_par_bad, ad_bad;
    logic       wr_err;
    logic [0:7] wr_code;

    assign state_dbg = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            tag_q      <= 8'h00;
            mask_q     <= 2'b00;
            pend_q     <= 1'b0;
            pcode_q    <= 8'h00;
            busy       <= 1'b0;
            wed_valid  <= 1'b0;
            wed_error  <= 1'b0;
            wed_status <= 8'h00;
            wed_data   <= '0;
        end else begin
            state      <= state_n;
            tag_q      <= tag_n;
            mask_q     <= mask_n;
            pend_q     <= pend_n;
            pcode_q    <= pcode_n;
            busy       <= busy_n;
            wed_valid  <= valid_n;
            wed_error  <= error_n;
            wed_status <= status_n;
            wed_data   <= data_n;
        end
    end

    always_comb begin
        state_n  = state;
        tag_n    = tag_q;
        mask_n   = mask_q;
        pend_n   = pend_q;
        pcode_n  = pcode_q;
        valid_n  = wed_valid;
        error_n  = wed_error;
        status_n = wed_status;
        data_n   = wed_data;

        bw_hit        = (state == S_ARMED) && psl.ha_bwvalid && (psl.ha_bwtag == tag_q);
        r_hit         = (state == S_ARMED) && psl.ha_rvalid && (psl.ha_rtag == tag_q);
        bw_tagpar_bad = PARITY_EN && (psl.ha_bwtagpar != ^psl.ha_bwtag);
        r_tagpar_bad  = PARITY_EN && (psl.ha_rtagpar != ^psl.ha_rtag);
        ad_bad        = (psl.ha_bwad > 6'd1);

        data_par_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (psl.ha_bwpar[i] != ^psl.ha_bwdata[64*i +: 64]) data_par_bad = 1'b1;
        end
        data_par_bad = data_par_bad && PARITY_EN;

        // One code per write; a dropped beat makes its data parity irrelevant.
        wr_err  = 1'b1;
        wr_code = 8'h00;
        if (bw_tagpar_bad)     wr_code = 8'hE0;
        else if (ad_bad)       wr_code = 8'hE4;
        else if (data_par_bad) wr_code = 8'hE1;
        else                   wr_err  = 1'b0;

        case (state)
            S_ARMED: begin
                if (bw_hit) begin
                    if (!ad_bad) begin
                        if (psl.ha_bwad[5]) data_n[512:1023] = psl.ha_bwdata;
                        else                data_n[0:511]    = psl.ha_bwdata;
                        mask_n[psl.ha_bwad[5]] = 1'b1;
                    end
                    if (wr_err && !pend_q) begin
                        pend_n  = 1'b1;
                        pcode_n = wr_code;
                    end
                end
                // Evaluated against mask/pending including a same-cycle write.
                if (r_hit) begin
                    state_n = S_ERROR;
                    error_n = 1'b1;
                    if (r_tagpar_bad)                       status_n = 8'hE2;
                    else if (psl.ha_response != RESP_DONE)  status_n = psl.ha_response;
                    else if (pend_n)                        status_n = pcode_n;
                    else if (mask_n != 2'b11)               status_n = 8'hE3;
                    else begin
                        state_n  = S_DONE;
                        error_n  = 1'b0;
                        valid_n  = 1'b1;
                        status_n = 8'h00;
                    end
                end
            end
            default: begin
                if (arm) begin
                    state_n  = S_ARMED;
                    tag_n    = arm_tag;
                    mask_n   = 2'b00;
                    pend_n   = 1'b0;
                    pcode_n  = 8'h00;
                    valid_n  = 1'b0;
                    error_n  = 1'b0;
                    status_n = 8'h00;
                end
            end
        endcase

        busy_n = (state_n == S_ARMED);
    end

endmodule

// File: doc/wed_capture.md
Name: wed_capture

Overview:
- Consumes the PSL buffer-write and response streams that result from the WED read command issued by the command-generation stage.
- Collects the 128-byte WED as two 512-bit beats for one armed tag and checks tag and data parity.
- Qualifies completion against the PSL response code.
- Presents the WED to downstream job logic as a single 1024-bit vector with a valid or error indication.

Parameters:
PARITY_EN, 1, 1 = check ha_bwtagpar, ha_bwpar and ha_rtagpar; 0 = ignore all parity inputs
RESP_DONE, 8'h00, response code meaning successful completion

Ports:
clock  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
arm  in  1  one-cycle pulse: the WED command has been issued with tag arm_tag
arm_tag  in  [0:7]  tag of the issued WED read command
ha_bwvalid  in  1  buffer write valid
ha_bwtag  in  [0:7]  buffer write tag
ha_bwtagpar  in  1  buffer write tag parity
ha_bwad  in  [0:5]  buffer write address (beat index)
ha_bwdata  in  [0:511]  buffer write data
ha_bwpar  in  [0:7]  parity, bit i covers ha_bwdata[64i : 64i+63]
ha_rvalid  in  1  response valid
ha_rtag  in  [0:7]  response tag
ha_rtagpar  in  1  response tag parity
ha_response  in  [0:7]  response code
busy  out  1  high while armed and awaiting completion
wed_valid  out  1  WED captured successfully; level signal
wed_data  out  [0:1023]  captured WED; beat 0 in bits [0:511], beat 1 in bits [512:1023]
wed_error  out  1  capture failed; level signal
wed_status  out  [0:7]  0 on success, otherwise an error code

Behaviour:
- Parity convention: each parity bit equals the XOR reduction of the bits it covers.
- Reset:
  - Reset state: IDLE; busy=0, wed_valid=0, wed_error=0, wed_status=0, wed_data=0, beat mask=2'b00, pending error cleared.
  - Reset mid-capture aborts the capture; writes and responses after reset are ignored until the next arm.
- States: IDLE, ARMED, DONE, ERROR. All outputs are registered.
- Arm:
  - arm in IDLE, DONE or ERROR: latch arm_tag; clear beat mask, pending error, wed_valid, wed_error, wed_status; go to ARMED; busy=1 from the next cycle.
  - wed_data is not cleared on arm.
  - arm while in ARMED is ignored; the latched tag is kept.
- Buffer write in ARMED, only when ha_bwvalid=1 and ha_bwtag equals the latched tag (non-matching writes are ignored entirely):
  - ha_bwad 0 or 1: write ha_bwdata into the corresponding half of wed_data and set the mask bit. A repeated beat overwrites the data; the mask stays set.
  - ha_bwad >= 2: data is dropped; pending error 8'hE4.
  - With PARITY_EN=1, a tag-parity mismatch sets pending error 8'hE0. Any ha_bwpar bit mismatch sets pending error 8'hE1; the data is still stored.
  - Pending error keeps the first code recorded.
- Response in ARMED, only when ha_rvalid=1 and ha_rtag equals the latched tag. Priority:
  1. Response tag parity bad (PARITY_EN=1): ERROR, status 8'hE2.
  2. ha_response != RESP_DONE: ERROR, status = ha_response.
  3. Pending error set: ERROR, status = pending code.
  4. Mask not 2'b11: ERROR, status 8'hE3.
  5. Otherwise: DONE, status 8'h00.
- A matching buffer write in the same cycle as the response counts toward the mask and toward pending parity for that response's evaluation.
- Latency: wed_valid or wed_error asserts, and busy deasserts, exactly 1 cycle after the response is sampled.
- wed_valid, wed_error and wed_status hold until the next arm or reset.
- Writes and responses received in IDLE, DONE or ERROR are ignored.

Test Plan:
- Normal capture: arm tag 8'hFF; beat 0 = 64'h0123456789ABCDEF repeated, beat 1 = all 8'hA5; correct parity; response 8'h00 -> next cycle wed_valid=1, wed_status=0, wed_data matches both beats, busy=0.
- Reverse order with same-cycle response: write beat 1 first, then beat 0 together with the response in one cycle -> wed_valid=1 with correct data.
- Missing beat: arm tag 8'h05; write beat 0 only; response 8'h00 -> wed_error=1, wed_status=8'hE3.
- Data parity: flip ha_bwpar[3] on beat 1 -> wed_error=1, status 8'hE1. Repeat with PARITY_EN=0 -> wed_valid=1.
- Foreign traffic and failure response: writes and responses with tag 8'h01 while armed on 8'hFF leave busy=1 with no output change; a matching response 8'h03 -> wed_error=1, status 8'h03.
- Reset and re-arm: reset asserted after beat 0 -> all outputs 0 and state IDLE, following writes ignored; re-arm and complete -> wed_valid=1.
